trap_arbiter: RTL and testbench
===============================

TRAP_ARBITER -- requirements
Module: trap_arbiter

Interface
REQ-001 Parameter XLEN, default 32: width of PC, tval and cause datapaths.
REQ-002 Parameter NIRQ, default 12, legal range 12..XLEN-1: number of interrupt lines.
REQ-003 Parameter SYNC_STG, default 2, minimum 2: synchronizer depth on irq_raw.
REQ-004 Parameter FLUSH_CYC, default 2, minimum 1: cycles flush is held after acknowledge.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-007 Port rst, input, 1: synchronous active-high reset.
REQ-008 Port inst_valid, input, 1: the commit-point instruction is valid.
REQ-009 Port exc_vec, input, 16: one bit per exception cause code 0..15 for the commit instruction.
REQ-010 Port exc_pc, input, XLEN: PC of the commit instruction.
REQ-011 Port exc_tval, input, XLEN: trap value supplied with the exception.
REQ-012 Port irq_raw, input, NIRQ: asynchronous level interrupt lines.
REQ-013 Port irq_en, input, NIRQ: per-line enable (mie & delegation, resolved upstream).
REQ-014 Port glb_ie, input, 1: global interrupt enable.
REQ-015 Port trap_ack, input, 1: CSR unit accepts the presented trap.
REQ-016 Port trap_req, output, 1: a trap is presented.
REQ-017 Port trap_cause, output, XLEN: bit XLEN-1 = interrupt flag; bits 4:0 = code for codes below 32, remaining bits 0.
REQ-018 Port trap_epc, output, XLEN: trap PC.
REQ-019 Port trap_val, output, XLEN: trap value.
REQ-020 Port flush, output, 1: pipeline flush.
REQ-021 Port busy, output, 1: state is not IDLE.
REQ-022 Port irq_pend, output, NIRQ: synchronized irq_raw & irq_en.

Function
REQ-023 irq_raw SHALL pass through a SYNC_STG-flop synchronizer per line; irq_pend SHALL be its output ANDed with irq_en, combinationally.
REQ-024 The FSM SHALL have states IDLE, REQ and FLUSH.
REQ-025 In IDLE with inst_valid=1, an interrupt is eligible when glb_ie=1 and irq_pend != 0.
REQ-026 In IDLE with inst_valid=1, an exception is eligible when exc_vec != 0.
REQ-027 An eligible interrupt SHALL win over an exception in the same cycle.
REQ-028 Interrupt priority: indices >=12 outrank standard lines, higher index wins among them; then 11,3,7,9,1,5,10,2,6,8,0,4.
REQ-029 Exception priority: 3,12,1,0,2,11,9,8,6,4,15,13,7,5,10,14.
REQ-030 On winner selection the block SHALL capture cause, epc=exc_pc, val (exc_tval for an exception, 0 for an interrupt) into registers and move to REQ.
REQ-031 In REQ: trap_req=1 and trap_cause, trap_epc and trap_val SHALL stay stable until trap_ack.
REQ-032 In REQ, input changes SHALL be ignored.
REQ-033 trap_ack sampled high in REQ SHALL move to FLUSH; trap_ack in any other state SHALL be ignored.
REQ-034 In FLUSH: flush=1 for exactly FLUSH_CYC cycles via a down-counter, then return to IDLE; trap_req=0.
REQ-035 On return to IDLE, a new trap SHALL be selectable in the first IDLE cycle.
REQ-036 Interrupts arriving during REQ/FLUSH are not lost while the line stays asserted; a pulse deasserted before IDLE is dropped (level semantics).
REQ-037 trap_req SHALL be registered; latency from eligible input in IDLE to trap_req=1 is 1 cycle.
REQ-038 inst_valid=0 in IDLE SHALL suppress selection.

Reset
REQ-039 rst=1 SHALL force, on the next edge: state IDLE, trap_req=0, flush=0, busy=0, trap_cause/trap_epc/trap_val=0, synchronizer flops=0, flush counter=0, regardless of state (including mid-REQ or mid-FLUSH).

Verification
REQ-040 exc_vec=16'h0804 (codes 2,11), exc_pc=0x80, exc_tval=0x13, inst_valid=1 -> next cycle trap_req=1, trap_cause=2, trap_epc=0x80, trap_val=0x13.
REQ-041 irq_raw[7] and irq_raw[3] rise together, irq_en=all 1, glb_ie=1, exc_vec=16'h0004 -> after SYNC_STG+1 cycles trap_cause=0x80000003, trap_val=0.
REQ-042 Hold trap_ack=0 for 5 cycles while changing exc_vec -> outputs unchanged; then ack -> flush high exactly 2 cycles, busy falls next cycle.
REQ-043 Assert rst during FLUSH cycle 1 -> next cycle flush=0, busy=0, trap_req=0.
REQ-044 glb_ie=0 with irq_pend!=0 and exc_vec=0 -> no trap_req; glb_ie=1 -> trap_req next cycle.
REQ-045 NIRQ=16, irq_raw[13] and irq_raw[11] asserted -> trap_cause=0x8000000D.

Source files
------------

// File: rtl/trap_arbiter_if.sv
// Commit-point trap bus between the pipeline/CSR side and the trap arbiter.
// The arbiter connects through the slave modport; the driving side uses master.
interface trap_arbiter_if #(
   parameter int XLEN = 32,
   parameter int NIRQ = 12
);
   logic            inst_valid;
   logic [15:0]     exc_vec;
   logic [XLEN-1:0] exc_pc;
   logic [XLEN-1:0] exc_tval;
   logic [NIRQ-1:0] irq_raw;
   logic [NIRQ-1:0] irq_en;
   logic            glb_ie;
   logic            trap_ack;
   logic            trap_req;
   logic [XLEN-1:0] trap_cause;
   logic [XLEN-1:0] trap_epc;
   logic [XLEN-1:0] trap_val;
   logic            flush;
   logic            busy;
   logic [NIRQ-1:0] irq_pend;

   modport master (
      output inst_valid, exc_vec, exc_pc, exc_tval, irq_raw, irq_en, glb_ie, trap_ack,
      input  trap_req, trap_cause, trap_epc, trap_val, flush, busy, irq_pend
   );

   modport slave (
      input  inst_valid, exc_vec, exc_pc, exc_tval, irq_raw, irq_en, glb_ie, trap_ack,
      output trap_req, trap_cause, trap_epc, trap_val, flush, busy, irq_pend
   );
endinterface

// File: rtl/trap_arbiter.sv
// Trap arbiter: picks one interrupt or exception at the commit point, holds it
// for the CSR unit until acknowledged, then flushes the pipeline.
module trap_arbiter #(
   parameter int XLEN      = 32,
   parameter int NIRQ      = 12,
   parameter int SYNC_STG  = 2,
   parameter int FLUSH_CYC = 2
) (
   input logic         clk,
   input logic         rst,
   trap_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] REQ   = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;

   localparam int CNT_W = $clog2(FLUSH_CYC + 1);
   localparam int IDX_W = $clog2(NIRQ);

   // Priority tables listed lowest first, so the last hit in a scan wins.
   localparam int IRQ_STD [12] = '{4, 0, 8, 6, 2, 10, 5, 1, 9, 7, 3, 11};
   localparam int EXC_ORD [16] = '{14, 10, 5, 7, 13, 15, 4, 6, 8, 9, 11, 2, 0, 1, 12, 3};

   logic [NIRQ-1:0]  sync_q [SYNC_STG];
   logic [NIRQ-1:0]  irq_pend;
   logic [1:0]       state;
   logic [CNT_W-1:0] flush_cnt;
   logic             req_q;
   logic             flush_q;
   logic [XLEN-1:0]  cause_q;
   logic [XLEN-1:0]  epc_q;
   logic [XLEN-1:0]  val_q;

   logic             irq_hit;
   logic [IDX_W-1:0] irq_code;
   logic             exc_hit;
   logic [3:0]       exc_code;
   logic             int_ok;
   logic [XLEN-1:0]  cause_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STG; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= bus.irq_raw;
         for (int i = 1; i < SYNC_STG; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign irq_pend = sync_q[SYNC_STG-1] & bus.irq_en;

   // Lines 12 and up outrank every standard line, higher index first.
   always_comb begin
      irq_hit  = 1'b0;
      irq_code = '0;
      for (int j = 0; j < 12; j++) begin
         if (irq_pend[IRQ_STD[j]]) begin
            irq_hit  = 1'b1;
            irq_code = IDX_W'(IRQ_STD[j]);
         end
      end
      for (int i = 12; i < NIRQ; i++) begin
         if (irq_pend[i]) begin
            irq_hit  = 1'b1;
            irq_code = IDX_W'(i);
         end
      end
   end

   always_comb begin
      exc_hit  = |bus.exc_vec;
      exc_code = '0;
      for (int j = 0; j < 16; j++) begin
         if (bus.exc_vec[EXC_ORD[j]]) exc_code = 4'(EXC_ORD[j]);
      end
   end

   always_comb begin
      int_ok    = bus.glb_ie & irq_hit;
      cause_nxt = '0;
      if (int_ok) begin
         cause_nxt[XLEN-1]    = 1'b1;
         cause_nxt[IDX_W-1:0] = irq_code;
      end else begin
         cause_nxt[3:0] = exc_code;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         req_q     <= 1'b0;
         flush_q   <= 1'b0;
         flush_cnt <= '0;
         cause_q   <= '0;
         epc_q     <= '0;
         val_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.inst_valid && (int_ok || exc_hit)) begin
                  cause_q <= cause_nxt;
                  epc_q   <= bus.exc_pc;
                  val_q   <= int_ok ? '0 : bus.exc_tval;
                  req_q   <= 1'b1;
                  state   <= REQ;
               end
            end
            REQ: begin
               if (bus.trap_ack) begin
                  req_q     <= 1'b0;
                  flush_q   <= 1'b1;
                  flush_cnt <= CNT_W'(FLUSH_CYC);
                  state     <= FLUSH;
               end
            end
            FLUSH: begin
               flush_cnt <= flush_cnt - CNT_W'(1);
               if (flush_cnt == CNT_W'(1)) begin
                  flush_q <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               req_q   <= 1'b0;
               flush_q <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.trap_req   = req_q;
   assign bus.trap_cause = cause_q;
   assign bus.trap_epc   = epc_q;
   assign bus.trap_val   = val_q;
   assign bus.flush      = flush_q;
   assign bus.busy       = (state != IDLE);
   assign bus.irq_pend   = irq_pend;
endmodule

// File: tb/tb_trap_arbiter.sv
// Self-checking bench for trap_arbiter: a priority-list reference model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_trap_arbiter;
   localparam int XLEN      = 32;
   localparam int NIRQ      = 16;
   localparam int SYNC_STG  = 2;
   localparam int FLUSH_CYC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   bit   chk_en = 1'b0;

   trap_arbiter_if #(.XLEN(XLEN), .NIRQ(NIRQ)) bus();

   trap_arbiter #(
      .XLEN(XLEN), .NIRQ(NIRQ), .SYNC_STG(SYNC_STG), .FLUSH_CYC(FLUSH_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int irq_std [12] = '{11, 3, 7, 9, 1, 5, 10, 2, 6, 8, 0, 4};
   int exc_pri [16] = '{3, 12, 1, 0, 2, 11, 9, 8, 6, 4, 15, 13, 7, 5, 10, 14};

   // Model: mode 0 = idle, 1 = presenting a trap, 2 = flushing.
   int              m_mode = 0;
   int              m_left = 0;
   logic [31:0]     m_cause = '0;
   logic [31:0]     m_epc = '0;
   logic [31:0]     m_val = '0;
   logic [NIRQ-1:0] m_hist [$];

   function automatic int pick_irq(input logic [NIRQ-1:0] p);
      for (int i = NIRQ - 1; i >= 12; i--) if (p[i]) return i;
      for (int j = 0; j < 12; j++) if (p[irq_std[j]]) return irq_std[j];
      return -1;
   endfunction

   function automatic int pick_exc(input logic [15:0] v);
      for (int j = 0; j < 16; j++) if (v[exc_pri[j]]) return exc_pri[j];
      return -1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin : model
      logic [NIRQ-1:0] pend;
      int w;
      pend = m_hist[SYNC_STG-1] & bus.irq_en;
      if (rst) begin
         m_mode  = 0;
         m_left  = 0;
         m_cause = '0;
         m_epc   = '0;
         m_val   = '0;
         m_hist.delete();
         repeat (SYNC_STG) m_hist.push_back('0);
      end else begin
         case (m_mode)
            0: if (bus.inst_valid) begin
               w = bus.glb_ie ? pick_irq(pend) : -1;
               if (w >= 0) begin
                  m_cause = 32'h8000_0000 | w;
                  m_val   = '0;
                  m_epc   = bus.exc_pc;
                  m_mode  = 1;
               end else begin
                  w = pick_exc(bus.exc_vec);
                  if (w >= 0) begin
                     m_cause = w;
                     m_val   = bus.exc_tval;
                     m_epc   = bus.exc_pc;
                     m_mode  = 1;
                  end
               end
            end
            1: if (bus.trap_ack) begin
               m_mode = 2;
               m_left = FLUSH_CYC;
            end
            default: begin
               m_left--;
               if (m_left == 0) m_mode = 0;
            end
         endcase
         m_hist.push_front(bus.irq_raw);
         void'(m_hist.pop_back());
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         checkOutput("m_trap_req", 32'(bus.trap_req), 32'(m_mode == 1));
         checkOutput("m_flush", 32'(bus.flush), 32'(m_mode == 2));
         checkOutput("m_busy", 32'(bus.busy), 32'(m_mode != 0));
         checkOutput("m_cause", bus.trap_cause, m_cause);
         checkOutput("m_epc", bus.trap_epc, m_epc);
         checkOutput("m_val", bus.trap_val, m_val);
         checkOutput("m_irq_pend", 32'(bus.irq_pend), 32'(m_hist[SYNC_STG-1] & bus.irq_en));
      end
   end

   task automatic applyStimulus(input logic iv, input logic [15:0] ev, input logic [31:0] pc,
                                input logic [31:0] tval, input logic [NIRQ-1:0] raw,
                                input logic [NIRQ-1:0] en, input logic gie, input logic ack,
                                input int cycles);
      bus.inst_valid = iv;
      bus.exc_vec    = ev;
      bus.exc_pc     = pc;
      bus.exc_tval   = tval;
      bus.irq_raw    = raw;
      bus.irq_en     = en;
      bus.glb_ie     = gie;
      bus.trap_ack   = ack;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Acknowledge the current trap and let the flush drain back to idle.
   task automatic finishTrap();
      applyStimulus(1'b0, '0, '0, '0, '0, '1, 1'b1, 1'b1, 1);
      applyStimulus(1'b0, '0, '0, '0, '0, '1, 1'b1, 1'b0, 3);
   endtask

   initial begin
      logic [NIRQ-1:0] raw;
      logic [NIRQ-1:0] en;
      m_hist.delete();
      repeat (SYNC_STG) m_hist.push_back('0);

      rst = 1'b1;
      applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 2);
      rst = 1'b0;
      chk_en = 1'b1;
      checkOutput("rst_trap_req", 32'(bus.trap_req), 32'd0);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_flush", 32'(bus.flush), 32'd0);
      checkOutput("rst_cause", bus.trap_cause, 32'd0);

      applyStimulus(1'b1, 16'h0804, 32'h80, 32'h13, '0, '0, 1'b0, 1'b0, 1);
      checkOutput("exc_trap_req", 32'(bus.trap_req), 32'd1);
      checkOutput("exc_cause", bus.trap_cause, 32'd2);
      checkOutput("exc_epc", bus.trap_epc, 32'h80);
      checkOutput("exc_val", bus.trap_val, 32'h13);

      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b1, 16'($urandom) | 16'h1, $urandom, $urandom, '0, '0, 1'b0, 1'b0, 1);
         checkOutput("hold_cause", bus.trap_cause, 32'd2);
         checkOutput("hold_epc", bus.trap_epc, 32'h80);
         checkOutput("hold_req", 32'(bus.trap_req), 32'd1);
      end
      applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 1);
      checkOutput("ack_flush1", 32'(bus.flush), 32'd1);
      checkOutput("ack_req_low", 32'(bus.trap_req), 32'd0);
      applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 1);
      checkOutput("ack_flush2", 32'(bus.flush), 32'd1);
      applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1);
      checkOutput("flush_end", 32'(bus.flush), 32'd0);
      checkOutput("busy_end", 32'(bus.busy), 32'd0);

      applyStimulus(1'b0, 16'h0004, 32'h100, 32'h55, 16'h0088, '1, 1'b1, 1'b0, 2);
      checkOutput("iv0_suppress", 32'(bus.trap_req), 32'd0);
      checkOutput("sync_pend", 32'(bus.irq_pend), 32'h0088);
      applyStimulus(1'b1, 16'h0004, 32'h100, 32'h55, 16'h0088, '1, 1'b1, 1'b0, 1);
      checkOutput("irq_cause", bus.trap_cause, 32'h8000_0003);
      checkOutput("irq_val", bus.trap_val, 32'd0);
      checkOutput("irq_epc", bus.trap_epc, 32'h100);
      finishTrap();

      applyStimulus(1'b1, 16'h0001, 32'h200, 32'h7, '0, '1, 1'b1, 1'b0, 1);
      checkOutput("exc0_cause", bus.trap_cause, 32'd0);
      checkOutput("exc0_val", bus.trap_val, 32'h7);
      applyStimulus(1'b0, '0, '0, '0, '0, '1, 1'b1, 1'b1, 1);
      checkOutput("pre_rst_flush", 32'(bus.flush), 32'd1);
      rst = 1'b1;
      applyStimulus(1'b0, '0, '0, '0, '0, '1, 1'b1, 1'b0, 1);
      rst = 1'b0;
      checkOutput("midflush_rst_flush", 32'(bus.flush), 32'd0);
      checkOutput("midflush_rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("midflush_rst_epc", bus.trap_epc, 32'd0);

      applyStimulus(1'b1, '0, 32'h300, '0, 16'h0020, '1, 1'b0, 1'b0, 4);
      checkOutput("gie0_no_req", 32'(bus.trap_req), 32'd0);
      checkOutput("gie0_pend", 32'(bus.irq_pend), 32'h0020);
      applyStimulus(1'b1, '0, 32'h300, '0, 16'h0020, '1, 1'b1, 1'b0, 1);
      checkOutput("gie1_req", 32'(bus.trap_req), 32'd1);
      checkOutput("gie1_cause", bus.trap_cause, 32'h8000_0005);
      finishTrap();

      applyStimulus(1'b1, 16'hFFFF, 32'h400, 32'h1, '0, '1, 1'b1, 1'b0, 1);
      checkOutput("exc_all_cause", bus.trap_cause, 32'd3);
      finishTrap();
      applyStimulus(1'b1, 16'h1002, 32'h404, 32'h2, '0, '1, 1'b1, 1'b0, 1);
      checkOutput("exc_1_12_cause", bus.trap_cause, 32'd12);
      finishTrap();

      applyStimulus(1'b0, '0, '0, '0, 16'h2800, '1, 1'b1, 1'b0, 2);
      applyStimulus(1'b1, '0, 32'h500, '0, 16'h2800, '1, 1'b1, 1'b0, 1);
      checkOutput("irq13_cause", bus.trap_cause, 32'h8000_000D);
      finishTrap();

      raw = '0;
      en  = '1;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) == 0) raw = NIRQ'($urandom & $urandom);
         if ($urandom_range(0, 15) == 0) en = NIRQ'($urandom);
         rst = ($urandom_range(0, 99) == 0);
         applyStimulus($urandom_range(0, 3) != 0,
                       ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0,
                       $urandom, $urandom, raw, en,
                       $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 1);
      end
      rst = 1'b0;
      applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
